// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the fifo round-robin scheduler.
//   sched_state_e : scheduler FSM encoding (idle arbitration / burst drain)
//   eff_burst()   : maps a burst_len field to its effective word count
package fifo_sched_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } sched_state_e;

  // A length field of zero encodes the maximum burst of 2^bits words.
  function automatic int unsigned eff_burst(input int unsigned len, input int unsigned bits);
    return (len == 0) ? (32'd1 << bits) : len;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Scans last_i+1, last_i+2, ... modulo NumPorts and returns the first requester.
//   req_i     : request vector, one bit per port
//   last_i    : index of the most recently served port (lowest priority)
//   grant_o   : index of the selected port (0 when nothing requests)
//   any_req_o : at least one request is present
module rr_priority_picker #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned PortBits = 2
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [PortBits-1:0] last_i,
  output logic [PortBits-1:0] grant_o,
  output logic                any_req_o
);

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    for (int unsigned k = 1; k <= NumPorts; k++) begin
      automatic int unsigned         idx   = (32'(last_i) + k) % NumPorts;
      automatic logic [PortBits-1:0] idx_p = PortBits'(idx);
      if (!any_req_o && req_i[idx_p]) begin
        any_req_o = 1'b1;
        grant_o   = idx_p;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler draining NumPorts first-word-fall-through fifos into one
// registered valid/ready output channel. A grant is held for a burst of words,
// then priority rotates past the served port.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   enable_i           : allows new grants and reads
//   burst_len_i        : words per grant (0 = 2^BurstBits), sampled at grant time
//   fifo_empty_i       : per-fifo empty flags, used only for arbitration in idle
//   fifo_valid_i       : per-fifo valid flags, qualified by peek
//   fifo_data_i        : per-fifo read data, port i at [i*DataWidth +: DataWidth]
//   fifo_rd_en_o       : dequeue strobe, at most one bit set
//   fifo_peek_o        : granted port while a burst is active
//   out_data_o/port_o  : registered output word and its source index
//   out_valid_o        : output register holds a word
//   out_ready_i        : consumer accepts the word this cycle
//   grant_active_o     : a burst is active
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned PortBits  = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BurstBits = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [BurstBits-1:0]          burst_len_i,
  input  logic [NumPorts-1:0]           fifo_empty_i,
  input  logic [NumPorts-1:0]           fifo_valid_i,
  input  logic [NumPorts*DataWidth-1:0] fifo_data_i,
  output logic [NumPorts-1:0]           fifo_rd_en_o,
  output logic [NumPorts-1:0]           fifo_peek_o,
  output logic [DataWidth-1:0]          out_data_o,
  output logic [PortBits-1:0]           out_port_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          grant_active_o
);

  localparam int unsigned CntW = BurstBits + 1;

  sched_state_e         state_q, state_d;
  logic [PortBits-1:0]  grant_q, grant_d;
  logic [PortBits-1:0]  last_q, last_d;
  logic [CntW-1:0]      len_q, len_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [PortBits-1:0]  out_port_q, out_port_d;
  logic                 out_valid_q, out_valid_d;

  logic [PortBits-1:0]  pick;
  logic                 any_req;
  logic                 can_accept;
  logic                 g_valid;
  logic [DataWidth-1:0] g_data;
  logic                 rd;

  rr_priority_picker #(
    .NumPorts (NumPorts),
    .PortBits (PortBits)
  ) u_picker (
    .req_i     (~fifo_empty_i),
    .last_i    (last_q),
    .grant_o   (pick),
    .any_req_o (any_req)
  );

  assign can_accept = ~out_valid_q | out_ready_i;
  assign g_valid    = fifo_valid_i[grant_q];
  assign g_data     = fifo_data_i[grant_q*DataWidth +: DataWidth];
  // Deliberately independent of fifo_empty_i: the fifo's empty flag reacts to rdEn.
  assign rd         = (state_q == StBurst) & enable_i & g_valid & can_accept;

  always_comb begin
    fifo_rd_en_o = '0;
    fifo_peek_o  = '0;
    if (state_q == StBurst) begin
      fifo_peek_o[grant_q]  = 1'b1;
      fifo_rd_en_o[grant_q] = rd;
    end
  end

  // FSM, burst counter and grant bookkeeping.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i && any_req) begin
          state_d = StBurst;
          grant_d = pick;
          len_d   = CntW'(eff_burst(32'(burst_len_i), BurstBits));
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (rd) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == len_q - CntW'(1)) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end else if (!enable_i || !g_valid) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
        // Otherwise backpressure: hold the grant and the count.
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register: a load wins over a same-cycle drain.
  always_comb begin
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    out_valid_d = out_valid_q;
    if (rd) begin
      out_data_d  = g_data;
      out_port_d  = grant_q;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= PortBits'(NumPorts - 1);
      len_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o     = out_data_q;
  assign out_port_o     = out_port_q;
  assign out_valid_o    = out_valid_q;
  assign grant_active_o = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
module tb_fifo_rr_scheduler;

  localparam int NP = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic [1:0]     burst_len = 2'd0;
  logic [NP-1:0]  fifo_empty;
  logic [NP-1:0]  fifo_valid;
  logic [NP*DW-1:0] fifo_data;
  logic [NP-1:0]  fifo_rd_en;
  logic [NP-1:0]  fifo_peek;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_port;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           grant_active;

  int n_checks = 0;
  int n_fail   = 0;

  // Source fifo models: circular buffers, popped on rdEn at the clock edge.
  logic [DW-1:0] mem [NP][64];
  logic [5:0]    head [NP] = '{6'd0, 6'd0, 6'd0, 6'd0};
  logic [5:0]    tail [NP] = '{6'd0, 6'd0, 6'd0, 6'd0};

  // Scoreboard of {port, data} words expected at the output, in order.
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p]           = (head[p] == tail[p]);
      fifo_valid[p]           = (head[p] != tail[p]);
      fifo_data[p*DW +: DW]   = mem[p][head[p]];
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (fifo_rd_en[p]) head[p] <= head[p] + 6'd1;
  end

  fifo_rr_scheduler #(
    .NumPorts  (4),
    .PortBits  (2),
    .DataWidth (32),
    .BurstBits (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .burst_len_i    (burst_len),
    .fifo_empty_i   (fifo_empty),
    .fifo_valid_i   (fifo_valid),
    .fifo_data_i    (fifo_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_peek_o    (fifo_peek),
    .out_data_o     (out_data),
    .out_port_o     (out_port),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .grant_active_o (grant_active)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int p, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[p][tail[p]] = DW'(base + i);
      tail[p] = tail[p] + 6'd1;
    end
  endtask

  task automatic push(input int p, input int d);
    exp_q.push_back({2'(p), DW'(d)});
  endtask

  // Compares every accepted output word against the scoreboard, just before each rising edge.
  task automatic monitor();
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_word", 64'({out_port, out_data}), 64'(e));
        end
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset held with every fifo non-empty.
    #1 rst_n = 1'b0;
    for (int p = 0; p < NP; p++) load(p, 'hA0 + p, 1);
    burst_len = 2'd2;
    enable    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_rden", 64'(fifo_rd_en), 64'd0);
    check("rst_peek", 64'(fifo_peek), 64'd0);
    check("rst_grant", 64'(grant_active), 64'd0);
    for (int p = 0; p < NP; p++) push(p, 'hA0 + p);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_valid", 64'(out_valid), 64'd0);
    check("first_edge_rden", 64'(fifo_rd_en), 64'b0001);
    @(negedge clk);
    check("second_edge_valid", 64'(out_valid), 64'd1);
    check("second_edge_port", 64'(out_port), 64'd0);
    wait_drain("drain_reset", 100);

    // Rotation: burst of 2 over four ports of 4 words each.
    burst_len = 2'd2;
    for (int p = 0; p < NP; p++) load(p, p * 16, 4);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        for (int i = 0; i < 2; i++) push(p, p * 16 + r * 2 + i);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("rot_gap", 64'(out_valid), 64'((k % 3) != 1));
    end
    wait_drain("drain_rotation", 100);

    // Backpressure mid-burst on port 3 (only non-empty port).
    burst_len = 2'd0;
    load(3, 'h30, 4);
    for (int i = 0; i < 4; i++) push(3, 'h30 + i);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("bp_rden_now", 64'(fifo_rd_en), 64'd0);
    check("bp_data_now", 64'(out_data), 64'h31);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_data_hold", 64'(out_data), 64'h31);
      check("bp_rden_hold", 64'(fifo_rd_en), 64'd0);
      check("bp_grant_hold", 64'(fifo_peek), 64'b1000);
    end
    out_ready = 1'b1;
    wait_drain("drain_backpressure", 100);

    // Early drain of port 1 and maximum burst length.
    burst_len = 2'd0;
    load(0, 'h100, 8);
    load(1, 'h110, 1);
    load(2, 'h120, 8);
    load(3, 'h130, 8);
    for (int i = 0; i < 4; i++) push(0, 'h100 + i);
    push(1, 'h110);
    for (int i = 0; i < 4; i++) push(2, 'h120 + i);
    for (int i = 0; i < 4; i++) push(3, 'h130 + i);
    for (int i = 4; i < 8; i++) push(0, 'h100 + i);
    for (int i = 4; i < 8; i++) push(2, 'h120 + i);
    for (int i = 4; i < 8; i++) push(3, 'h130 + i);
    wait_drain("drain_maxburst", 200);

    // Enable drop after the first word of a burst.
    load(0, 'h60, 4);
    load(1, 'h70, 4);
    push(0, 'h60);
    for (int i = 0; i < 4; i++) push(1, 'h70 + i);
    for (int i = 1; i < 4; i++) push(0, 'h60 + i);
    @(negedge clk);
    check("en_peek_p0", 64'(fifo_peek), 64'b0001);
    @(negedge clk);
    check("en_first_word", 64'(out_data), 64'h60);
    enable = 1'b0;
    #1;
    check("en_off_rden", 64'(fifo_rd_en), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("en_off_rden_hold", 64'(fifo_rd_en), 64'd0);
      check("en_off_idle", 64'(grant_active), 64'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("en_next_grant_p1", 64'(fifo_peek), 64'b0010);
    wait_drain("drain_enable", 100);

    // Asynchronous reset between clock edges mid-burst.
    burst_len = 2'd0;
    load(2, 'hC0, 4);
    repeat (2) @(negedge clk);
    check("ar_valid_before", 64'(out_valid), 64'd1);
    check("ar_data_before", 64'(out_data), 64'hC0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_async", 64'(out_valid), 64'd0);
    check("ar_rden_async", 64'(fifo_rd_en), 64'd0);
    check("ar_peek_async", 64'(fifo_peek), 64'd0);
    exp_q.delete();
    for (int p = 0; p < NP; p++) tail[p] = head[p];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_after_idle", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
